alarm_entry_ctrl: RTL and testbench

Keypad-to-alarm entry controller sitting directly upstream of the alarm register. It collects BCD digit keystrokes into a four-digit HH:MM buffer and validates the result as a 24-hour time. It drives the register's `new_alarm_*` digit inputs and issues the one-cycle `load_new_alarm` strobe. Incomplete, invalid, cancelled or timed-out entries never reach the alarm register.

---
 rtl/alarm_clock_pkg.sv | 26 ++
 rtl/alarm_entry_ctrl_timeout.sv | 34 +++
 rtl/alarm_entry_ctrl.sv | 144 ++++++++++++++
 tb/tb_alarm_entry_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_pkg.sv
// Shared constants for the alarm clock keypad path: key codes, entry FSM
// encoding and the BCD limits of a 24-hour HH:MM time.
package alarm_clock_pkg;

  localparam logic [3:0] KEY_ALARM_CODE  = 4'd10;
  localparam logic [3:0] KEY_CANCEL_CODE = 4'd11;
  localparam logic [3:0] KEY_DIGIT_MAX   = 4'd9;

  localparam int HOURS_MAX   = 23;
  localparam int MINUTES_MAX = 59;

  // Per-digit limits derived from HH <= 23 and MM <= 59.
  localparam logic [3:0] BCD_DIGIT_MAX   = 4'd9;
  localparam logic [3:0] HR_TENS_MAX     = 4'(HOURS_MAX / 10);
  localparam logic [3:0] HR_UNITS_AT_TOP = 4'(HOURS_MAX % 10);
  localparam logic [3:0] MIN_TENS_MAX    = 4'(MINUTES_MAX / 10);

  localparam logic [2:0] DIGITS_FULL = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_LOAD  = 2'd2
  } entry_state_t;

endpackage

// File: rtl/alarm_entry_ctrl_timeout.sv
// Inactivity counter for an alarm entry: counts one_second ticks while enabled
// and pulses o_expire on the tick that reaches TIMEOUT_SEC.
module entry_timeout_counter #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_SEC + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_SEC - 1);

  logic [CW-1:0] r_count;
  logic          w_advance;

  // A key in the same cycle as a tick wins: the tick is not counted.
  assign w_advance = i_enable && i_tick && !i_clear;
  assign o_expire  = w_advance && (r_count == LAST_COUNT);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (!i_enable || i_clear || o_expire) begin
      r_count <= '0;
    end else if (w_advance) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_entry_ctrl.sv
// Keypad entry controller: collects four BCD digits as HH:MM, validates a
// 24-hour time and issues a one-cycle load strobe to the alarm register.
module alarm_entry_ctrl #(
  parameter int         TIMEOUT_SEC = 10,
  parameter logic [3:0] KEY_ALARM   = alarm_clock_pkg::KEY_ALARM_CODE,
  parameter logic [3:0] KEY_CANCEL  = alarm_clock_pkg::KEY_CANCEL_CODE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic       key_valid,
  input  logic [3:0] key,
  output logic [3:0] new_alarm_ms_hr,
  output logic [3:0] new_alarm_ls_hr,
  output logic [3:0] new_alarm_ms_min,
  output logic [3:0] new_alarm_ls_min,
  output logic       load_new_alarm,
  output logic       entry_active,
  output logic [2:0] digit_count,
  output logic       entry_error,
  output logic [1:0] dbg_state
);

  import alarm_clock_pkg::*;

  entry_state_t r_state;
  logic [3:0]   r_ms_hr, r_ls_hr, r_ms_min, r_ls_min;
  logic [2:0]   r_count;
  logic         r_load, r_error, r_active;

  logic w_key_digit, w_key_alarm, w_key_cancel, w_key_accept;
  logic w_commit_ok, w_expire;

  function automatic logic time_ok(input logic [3:0] h1, input logic [3:0] h0,
                                   input logic [3:0] m1, input logic [3:0] m0);
    logic hours_ok;
    hours_ok = ((h1 < HR_TENS_MAX) && (h0 <= BCD_DIGIT_MAX)) ||
               ((h1 == HR_TENS_MAX) && (h0 <= HR_UNITS_AT_TOP));
    return hours_ok && (m1 <= MIN_TENS_MAX) && (m0 <= BCD_DIGIT_MAX);
  endfunction

  assign w_key_digit  = key_valid && (key <= KEY_DIGIT_MAX);
  assign w_key_alarm  = key_valid && (key == KEY_ALARM);
  assign w_key_cancel = key_valid && (key == KEY_CANCEL);
  assign w_key_accept = w_key_digit || w_key_alarm || w_key_cancel;
  assign w_commit_ok  = (r_count == DIGITS_FULL) &&
                        time_ok(r_ms_hr, r_ls_hr, r_ms_min, r_ls_min);

  entry_timeout_counter #(
    .TIMEOUT_SEC(TIMEOUT_SEC)
  ) u_timeout (
    .i_clock (clock),
    .i_reset (reset),
    .i_enable(r_state == ST_ENTRY),
    .i_clear (w_key_accept),
    .i_tick  (one_second),
    .o_expire(w_expire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_ms_hr  <= '0;
      r_ls_hr  <= '0;
      r_ms_min <= '0;
      r_ls_min <= '0;
      r_count  <= '0;
      r_load   <= 1'b0;
      r_error  <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_load  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_key_alarm) begin
            r_state  <= ST_ENTRY;
            r_active <= 1'b1;
            r_ms_hr  <= '0;
            r_ls_hr  <= '0;
            r_ms_min <= '0;
            r_ls_min <= '0;
            r_count  <= '0;
          end
        end
        ST_ENTRY: begin
          if (w_key_digit) begin
            // A fifth digit is swallowed; it still restarts the timeout.
            if (r_count != DIGITS_FULL) begin
              r_ms_hr  <= r_ls_hr;
              r_ls_hr  <= r_ms_min;
              r_ms_min <= r_ls_min;
              r_ls_min <= key;
              r_count  <= r_count + 3'd1;
            end
          end else if (w_key_alarm) begin
            r_active <= 1'b0;
            if (w_commit_ok) begin
              r_state <= ST_LOAD;
              r_load  <= 1'b1;
            end else begin
              r_state  <= ST_IDLE;
              r_error  <= 1'b1;
              r_ms_hr  <= '0;
              r_ls_hr  <= '0;
              r_ms_min <= '0;
              r_ls_min <= '0;
              r_count  <= '0;
            end
          end else if (w_key_cancel || w_expire) begin
            r_state  <= ST_IDLE;
            r_active <= 1'b0;
            r_ms_hr  <= '0;
            r_ls_hr  <= '0;
            r_ms_min <= '0;
            r_ls_min <= '0;
            r_count  <= '0;
          end
        end
        ST_LOAD: begin
          // Buffer keeps the committed time so the alarm register sees it stable.
          r_state <= ST_IDLE;
          r_count <= '0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_active <= 1'b0;
          r_count  <= '0;
        end
      endcase
    end
  end

  assign new_alarm_ms_hr  = r_ms_hr;
  assign new_alarm_ls_hr  = r_ls_hr;
  assign new_alarm_ms_min = r_ms_min;
  assign new_alarm_ls_min = r_ls_min;
  assign load_new_alarm   = r_load;
  assign entry_error      = r_error;
  assign entry_active     = r_active;
  assign digit_count      = r_count;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_alarm_entry_ctrl.sv
// Bench for alarm_entry_ctrl: directed scenarios plus random key/tick traffic
// checked against a behavioural HH:MM entry model and a load scoreboard.
module tb_alarm_entry_ctrl;

  localparam int         T_SEC    = 3;
  localparam logic [3:0] K_ALARM  = 4'd10;
  localparam logic [3:0] K_CANCEL = 4'd11;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_LOAD = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       one_second = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'd0;
  logic [3:0] new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min;
  logic       load_new_alarm, entry_active, entry_error;
  logic [2:0] digit_count;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  int         m_mode;
  logic [3:0] m_buf[4];
  int         m_cnt;
  int         m_idle;
  logic       m_load, m_err;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [15:0] alarm_reg = 16'h0;

  wire [15:0] digits = {new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min};
  wire [21:0] dut_vec = {entry_active, digit_count, digits, load_new_alarm, entry_error};

  alarm_entry_ctrl #(
    .TIMEOUT_SEC(T_SEC),
    .KEY_ALARM  (K_ALARM),
    .KEY_CANCEL (K_CANCEL)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .one_second      (one_second),
    .key_valid       (key_valid),
    .key             (key),
    .new_alarm_ms_hr (new_alarm_ms_hr),
    .new_alarm_ls_hr (new_alarm_ls_hr),
    .new_alarm_ms_min(new_alarm_ms_min),
    .new_alarm_ls_min(new_alarm_ls_min),
    .load_new_alarm  (load_new_alarm),
    .entry_active    (entry_active),
    .digit_count     (digit_count),
    .entry_error     (entry_error),
    .dbg_state       (dbg_state)
  );

  // Clock / reset block
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Downstream alarm register captures on the load strobe.
  always @(posedge clock) begin
    if (reset && load_new_alarm) begin
      alarm_reg <= digits;
      got_q.push_back(digits);
    end
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_mode = M_IDLE;
    for (int i = 0; i < 4; i++) m_buf[i] = 4'd0;
    m_cnt = 0; m_idle = 0; m_load = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_buf[i] = 4'd0;
    m_cnt = 0;
    m_mode = M_IDLE;
  endtask

  function automatic bit model_time_valid();
    int hh, mm;
    hh = int'(m_buf[0]) * 10 + int'(m_buf[1]);
    mm = int'(m_buf[2]) * 10 + int'(m_buf[3]);
    return (hh <= 23) && (mm <= 59);
  endfunction

  task automatic model_step(input logic kv, input logic [3:0] k, input logic tk);
    bit accepted;
    accepted = kv && (k <= 4'd11);
    m_load = 1'b0;
    m_err  = 1'b0;
    if (m_mode == M_LOAD) begin
      exp_q.push_back({m_buf[0], m_buf[1], m_buf[2], m_buf[3]});
      m_mode = M_IDLE;
      m_cnt  = 0;
    end else if (m_mode == M_IDLE) begin
      if (kv && k == K_ALARM) begin
        model_clear();
        m_mode = M_ENTRY;
        m_idle = 0;
      end
    end else begin
      if (accepted) m_idle = 0;
      if (kv && k <= 4'd9) begin
        if (m_cnt < 4) begin
          m_buf[0] = m_buf[1]; m_buf[1] = m_buf[2]; m_buf[2] = m_buf[3]; m_buf[3] = k;
          m_cnt++;
        end
      end else if (kv && k == K_ALARM) begin
        if (m_cnt == 4 && model_time_valid()) begin
          m_mode = M_LOAD;
          m_load = 1'b1;
        end else begin
          m_err = 1'b1;
          model_clear();
        end
      end else if (kv && k == K_CANCEL) begin
        model_clear();
      end else if (tk) begin
        m_idle++;
        if (m_idle == T_SEC) begin
          model_clear();
          m_idle = 0;
        end
      end
    end
  endtask

  function automatic logic [21:0] model_vec();
    return {(m_mode == M_ENTRY), 3'(m_cnt), m_buf[0], m_buf[1], m_buf[2], m_buf[3], m_load, m_err};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic kv, input logic [3:0] k, input logic tk);
    key_valid = kv; key = k; one_second = tk;
    @(posedge clock);
    model_step(kv, k, tk);
    #1;
    key_valid = 1'b0; key = 4'd0; one_second = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    step(1'b1, k, 1'b0);
  endtask

  task automatic tick();
    step(1'b0, 4'd0, 1'b1);
  endtask

  task automatic enter_time(input logic [15:0] t);
    press(K_ALARM);
    for (int j = 0; j < 4; j++) press(t[15-4*j -: 4]);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    n_checks++;
    if (dut_vec !== 22'd0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got vec=%h state=%0d, want vec=0 state=0", dut_vec, dbg_state);
    end
    reset = 1'b1;
    @(negedge clock);
    press(K_ALARM); press(4'd1); press(4'd2);
    n_checks++;
    if (dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL reset_pre_entry: got %h want %h", dut_vec, model_vec());
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (dut_vec !== 22'd0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid_entry: got vec=%h state=%0d, want 0", dut_vec, dbg_state);
    end
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    press(K_ALARM);
    n_checks++;
    if (entry_active !== 1'b1 || digit_count !== 3'd0 || digits !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_clean_restart: got act=%b cnt=%0d dig=%h, want 1/0/0000",
               entry_active, digit_count, digits);
    end
    press(K_CANCEL);
  endtask

  task automatic test_valid_entry();
    enter_time(16'h0730);
    n_checks++;
    if (digits !== 16'h0730 || digit_count !== 3'd4 || load_new_alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_buffer: got dig=%h cnt=%0d load=%b, want 0730/4/0",
               digits, digit_count, load_new_alarm);
    end
    press(K_ALARM);
    n_checks++;
    if (load_new_alarm !== 1'b1 || entry_error !== 1'b0 || digits !== 16'h0730 || entry_active !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_load: got load=%b err=%b dig=%h act=%b, want 1/0/0730/0",
               load_new_alarm, entry_error, digits, entry_active);
    end
    step(1'b0, 4'd0, 1'b0);
    n_checks++;
    if (load_new_alarm !== 1'b0 || digit_count !== 3'd0 || digits !== 16'h0730 || alarm_reg !== 16'h0730) begin
      n_fail++;
      $display("FAIL valid_after_load: got load=%b cnt=%0d dig=%h reg=%h, want 0/0/0730/0730",
               load_new_alarm, digit_count, digits, alarm_reg);
    end
  endtask

  task automatic test_invalid_times();
    logic [15:0] tv[3];
    bit          ok[3];
    tv = '{16'h2415, 16'h1260, 16'h2359};
    ok = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      enter_time(tv[i]);
      press(K_ALARM);
      n_checks++;
      if (entry_error !== !ok[i] || load_new_alarm !== ok[i] ||
          digits !== (ok[i] ? tv[i] : 16'h0000)) begin
        n_fail++;
        $display("FAIL validate_%h: got err=%b load=%b dig=%h, want err=%b load=%b",
                 tv[i], entry_error, load_new_alarm, digits, !ok[i], ok[i]);
      end
      step(1'b0, 4'd0, 1'b0);
      n_checks++;
      if (entry_error !== 1'b0 || load_new_alarm !== 1'b0 || dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL validate_pulse_width_%h: got %h want %h", tv[i], dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_short_overflow_cancel();
    press(K_ALARM); press(4'd1); press(4'd2); press(K_ALARM);
    n_checks++;
    if (entry_error !== 1'b1 || load_new_alarm !== 1'b0 || entry_active !== 1'b0 || digits !== 16'h0) begin
      n_fail++;
      $display("FAIL short_entry: got err=%b load=%b act=%b dig=%h, want 1/0/0/0000",
               entry_error, load_new_alarm, entry_active, digits);
    end
    enter_time(16'h1234);
    press(4'd5);
    n_checks++;
    if (digits !== 16'h1234 || digit_count !== 3'd4 || entry_active !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_digit: got dig=%h cnt=%0d act=%b, want 1234/4/1",
               digits, digit_count, entry_active);
    end
    press(K_CANCEL);
    n_checks++;
    if (entry_active !== 1'b0 || entry_error !== 1'b0 || digit_count !== 3'd0 || digits !== 16'h0) begin
      n_fail++;
      $display("FAIL cancel: got act=%b err=%b cnt=%0d dig=%h, want 0/0/0/0000",
               entry_active, entry_error, digit_count, digits);
    end
  endtask

  task automatic test_timeout();
    press(K_ALARM); press(4'd1);
    tick();
    step(1'b1, 4'd5, 1'b1);
    tick(); tick();
    n_checks++;
    if (entry_active !== 1'b1 || digits !== 16'h0015 || digit_count !== 3'd2) begin
      n_fail++;
      $display("FAIL timeout_restart: got act=%b dig=%h cnt=%0d, want 1/0015/2",
               entry_active, digits, digit_count);
    end
    tick();
    n_checks++;
    if (entry_active !== 1'b0 || digits !== 16'h0 || digit_count !== 3'd0 || entry_error !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_expire: got act=%b dig=%h cnt=%0d err=%b, want 0/0000/0/0",
               entry_active, digits, digit_count, entry_error);
    end
    press(K_ALARM);
    tick();
    press(4'd13);
    step(1'b1, 4'd15, 1'b1);
    press(4'd12);
    tick();
    n_checks++;
    if (entry_active !== 1'b0 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL timeout_ignored_codes: got act=%b vec=%h, want act=0 vec=%h",
               entry_active, dut_vec, model_vec());
    end
  endtask

  task automatic test_back_to_back();
    enter_time(16'h2359);
    press(K_ALARM);
    press(K_ALARM);
    n_checks++;
    if (entry_active !== 1'b0 || load_new_alarm !== 1'b0 || alarm_reg !== 16'h2359) begin
      n_fail++;
      $display("FAIL key_in_load_ignored: got act=%b load=%b reg=%h, want 0/0/2359",
               entry_active, load_new_alarm, alarm_reg);
    end
    press(K_ALARM);
    n_checks++;
    if (entry_active !== 1'b1 || digit_count !== 3'd0 || digits !== 16'h0) begin
      n_fail++;
      $display("FAIL back_to_back_start: got act=%b cnt=%0d dig=%h, want 1/0/0000",
               entry_active, digit_count, digits);
    end
    for (int j = 0; j < 4; j++) press(4'd0);
    press(K_ALARM);
    n_checks++;
    if (load_new_alarm !== 1'b1 || digits !== 16'h0000) begin
      n_fail++;
      $display("FAIL midnight_load: got load=%b dig=%h, want 1/0000", load_new_alarm, digits);
    end
    enter_time(16'h1234);
    press(K_ALARM);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (load_new_alarm !== 1'b0 || dut_vec !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_in_load: got load=%b vec=%h, want 0/0", load_new_alarm, dut_vec);
    end
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    step(1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_random();
    int r;
    logic kv, tk;
    logic [3:0] k;
    int errs;
    errs = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
      end
      kv = ($urandom_range(0, 1) == 1);
      tk = ($urandom_range(0, 4) == 0);
      r  = $urandom_range(0, 99);
      if (r < 55)      k = 4'($urandom_range(0, 9));
      else if (r < 75) k = K_ALARM;
      else if (r < 80) k = K_CANCEL;
      else             k = 4'($urandom_range(12, 15));
      step(kv, k, tk);
      n_checks++;
      if (dut_vec !== model_vec() || (load_new_alarm && entry_error)) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_cycle_%0d: got %h want %h", n, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_scoreboard();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL load_count: got %0d loads, want %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [15:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL load_value: got %h want %h", g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_valid_entry();
    test_invalid_times();
    test_short_overflow_cancel();
    test_timeout();
    test_back_to_back();
    test_random();
    repeat (2) step(1'b0, 4'd0, 1'b0);
    test_scoreboard();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
